// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Conditions the raw DIP-switch inputs before they reach the LED/segment
// logic. Each bit is brought into the clk domain through a two-flop
// synchronizer. A bit's new level is accepted only after it has been seen
// for DEBOUNCE_CYCLES consecutive synchronized samples. All bits are
// independent.
//
// Ports
//   clk         in   1      system clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   sw_raw      in   WIDTH  raw asynchronous switch levels
//   s           out  WIDTH  debounced, synchronized switch value
//   s_changed   out  WIDTH  one-cycle strobe in the cycle s[i] takes a new value
//   any_change  out  1      OR of s_changed, registered together with it
//
// Timing: a level captured into the first synchronizer flop at edge k and
// held appears on s at edge k+1+DEBOUNCE_CYCLES.
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_changed,
  output logic             any_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Counter constants. CNT_W is at least 2 because DEBOUNCE_CYCLES >= 2.
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } bit_state_e;

  // Synchronizer stages
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Per-bit FSM state and stability counters
  bit_state_e       state_r   [WIDTH];
  bit_state_e       state_nxt_s [WIDTH];
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];

  // Acceptance events and next values of the registered outputs
  logic [WIDTH-1:0] accept_s;
  logic [WIDTH-1:0] s_nxt_s;
  logic [WIDTH-1:0] s_changed_nxt_s;
  logic             any_change_nxt_s;

  // Two-flop synchronizer; reset clears both stages so no flop is reset-less.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // State register: FSM state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= STABLE;
        cnt_r[i]   <= CNT_ZERO;
      end
      s          <= {WIDTH{1'b0}};
      s_changed  <= {WIDTH{1'b0}};
      any_change <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
      s          <= s_nxt_s;
      s_changed  <= s_changed_nxt_s;
      any_change <= any_change_nxt_s;
    end
  end

  // Next-state logic: per-bit stability tracking and acceptance decision.
  // The count is the number of consecutive samples that differ from s[i];
  // the DEBOUNCE_CYCLES-th such sample is the acceptance, so the counter
  // never climbs past DEBOUNCE_CYCLES-1.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      accept_s[i]    = 1'b0;
      case (state_r[i])
        STABLE: begin
          if (sync2_r[i] != s[i]) begin
            state_nxt_s[i] = PENDING;
            cnt_nxt_s[i]   = CNT_ONE;
          end else begin
            state_nxt_s[i] = STABLE;
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        end
        PENDING: begin
          if (sync2_r[i] == s[i]) begin
            // Bounced back before qualifying: drop the attempt silently.
            state_nxt_s[i] = STABLE;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_LAST) begin
            accept_s[i]    = 1'b1;
            state_nxt_s[i] = STABLE;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else begin
            state_nxt_s[i] = PENDING;
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s[i] = STABLE;
          cnt_nxt_s[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output logic: load the synchronized level on acceptance and form strobes.
  always_comb begin
    s_nxt_s          = s;
    s_changed_nxt_s  = accept_s;
    any_change_nxt_s = |accept_s;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept_s[i]) begin
        s_nxt_s[i] = sync2_r[i];
      end else begin
        s_nxt_s[i] = s[i];
      end
    end
  end

endmodule
